noc_local_injector: RTL and testbench

//  Network-interface transmitter for the router's local input port.
//  - Accepts one message per handshake from the attached core: MSG_W payload bits plus a 2-bit X and 2-bit Y destination.
//  - Splits the message into MSG_W/(WIDTH-4) flits and drives them on a valid/ready link into the router local input.
//  - Every flit carries the XY header in bits [7:6] (dest_x) and [5:4] (dest_y); the payload slice sits in [3:0].

---
 rtl/noc_pkg.sv | 30 +++
 rtl/noc_local_injector_if.sv | 27 ++
 rtl/noc_local_injector.sv | 90 +++++++++
 tb/tb_noc_local_injector.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout constants, injector FSM states and a flit builder.
package noc_pkg;

  localparam int FLIT_W    = 8;
  localparam int COORD_W   = 2;
  localparam int DEST_X_HI = 7;
  localparam int DEST_X_LO = 6;
  localparam int DEST_Y_HI = 5;
  localparam int DEST_Y_LO = 4;
  localparam int PAYLOAD_W = 4;

  typedef enum logic [0:0] {
    INJ_IDLE = 1'b0,
    INJ_SEND = 1'b1
  } inj_state_t;

  function automatic logic [FLIT_W-1:0] noc_make_flit(
    input logic [COORD_W-1:0]   dx,
    input logic [COORD_W-1:0]   dy,
    input logic [PAYLOAD_W-1:0] slice
  );
    logic [FLIT_W-1:0] f;
    f = '0;
    f[DEST_X_HI:DEST_X_LO] = dx;
    f[DEST_Y_HI:DEST_Y_LO] = dy;
    f[PAYLOAD_W-1:0]       = slice;
    return f;
  endfunction

endpackage

// File: rtl/noc_local_injector_if.sv
// Core-to-injector message handshake plus injector-to-router flit link.
interface noc_local_injector_if #(
  parameter int WIDTH = 8,
  parameter int MSG_W = 16
) ();

  logic             msg_valid;
  logic             msg_ready;
  logic [MSG_W-1:0] msg_data;
  logic [1:0]       msg_dest_x;
  logic [1:0]       msg_dest_y;
  logic [WIDTH-1:0] flit_data;
  logic             flit_valid;
  logic             flit_ready;

  // master: the injector itself; slave: the core/router side around it
  modport master (
    input  msg_valid, msg_data, msg_dest_x, msg_dest_y, flit_ready,
    output msg_ready, flit_data, flit_valid
  );

  modport slave (
    output msg_valid, msg_data, msg_dest_x, msg_dest_y, flit_ready,
    input  msg_ready, flit_data, flit_valid
  );

endinterface

// File: rtl/noc_local_injector.sv
// Local-port network interface: splits one core message into XY-headed flits for the router.
// Optional flit/message counters are built when NOC_INJ_STATS_EN is defined.
module noc_local_injector
  import noc_pkg::*;
#(
  parameter int WIDTH = FLIT_W,
  parameter int MSG_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  noc_local_injector_if.master link,
  output logic                busy,
  output logic [15:0]         stat_flits,
  output logic [15:0]         stat_msgs
);

  localparam int SLICE_W = WIDTH - 4;
  localparam int NFLITS  = MSG_W / SLICE_W;
  localparam int IDX_W   = (NFLITS > 1) ? $clog2(NFLITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFLITS - 1);

  localparam logic [0:0] ST_IDLE = INJ_IDLE;
  localparam logic [0:0] ST_SEND = INJ_SEND;

  logic [0:0]         state;
  logic [IDX_W-1:0]   idx;
  logic [MSG_W-1:0]   shreg;
  logic [COORD_W-1:0] dest_x;
  logic [COORD_W-1:0] dest_y;

  logic sending;
  logic xfer;
  logic last;
  logic accept;

  assign sending = (state == ST_SEND);
  assign xfer    = sending && link.flit_ready;
  assign last    = (idx == LAST_IDX);
  // Ready during the last-flit transfer lets the next message follow with no bubble
  assign link.msg_ready  = !sending || (xfer && last);
  assign accept          = link.msg_valid && link.msg_ready;
  assign link.flit_valid = sending;
  assign busy            = sending;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      shreg  <= '0;
      dest_x <= '0;
      dest_y <= '0;
    end else if (accept) begin
      state  <= ST_SEND;
      idx    <= '0;
      shreg  <= link.msg_data;
      dest_x <= link.msg_dest_x;
      dest_y <= link.msg_dest_y;
    end else if (xfer) begin
      shreg <= shreg >> SLICE_W;
      idx   <= idx + 1'b1;
      if (last) state <= ST_IDLE;
    end
  end

  // The current slice always sits in the low bits of the shift register
  generate
    if (WIDTH == FLIT_W) begin : g_std_flit
      assign link.flit_data = sending ? noc_make_flit(dest_x, dest_y, shreg[PAYLOAD_W-1:0]) : '0;
    end else begin : g_param_flit
      assign link.flit_data = sending ? {dest_x, dest_y, shreg[SLICE_W-1:0]} : '0;
    end
  endgenerate

`ifdef NOC_INJ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_flits <= '0;
      stat_msgs  <= '0;
    end else if (xfer) begin
      stat_flits <= stat_flits + 16'd1;
      if (last) stat_msgs <= stat_msgs + 16'd1;
    end
  end
`else
  assign stat_flits = 16'h0;
  assign stat_msgs  = 16'h0;
`endif

endmodule

// File: tb/tb_noc_local_injector.sv
// Bench for noc_local_injector: queue-based flit model checked every cycle, plus directed literal cases.
module tb_noc_local_injector;

  localparam int WIDTH  = 8;
  localparam int MSG_W  = 16;
  localparam int NFLITS = MSG_W / (WIDTH - 4);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] stat_flits;
  logic [15:0] stat_msgs;

  noc_local_injector_if #(.WIDTH(WIDTH), .MSG_W(MSG_W)) link ();

  noc_local_injector #(.WIDTH(WIDTH), .MSG_W(MSG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .link       (link),
    .busy       (busy),
    .stat_flits (stat_flits),
    .stat_msgs  (stat_msgs)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
  endtask

  // Model: flits still owed for the message in flight, oldest first
  logic [7:0] exp_q[$];
  logic [7:0] sent_log[$];
  int unsigned m_flits = 0;
  int unsigned m_msgs  = 0;

  function automatic void push_msg(input logic [15:0] data, input logic [1:0] dx, input logic [1:0] dy);
    for (int i = 0; i < NFLITS; i++) begin
      int v;
      v = int'(dx) * 64 + int'(dy) * 16 + ((int'(data) >> (4 * i)) & 15);
      exp_q.push_back(v[7:0]);
    end
  endfunction

  // Inputs change just after rising edges, so at the falling edge they are what the next edge samples
  always @(negedge clk) begin : compare
    bit mb, xf, rdy;
    if (!rst_n) begin
      exp_q.delete();
      m_flits = 0;
      m_msgs  = 0;
      check("rst_flit_valid", link.flit_valid, 0);
      check("rst_flit_data", link.flit_data, 0);
      check("rst_busy", busy, 0);
      check("rst_stat_flits", stat_flits, 0);
      check("rst_stat_msgs", stat_msgs, 0);
    end else begin
      mb  = (exp_q.size() != 0);
      xf  = mb && link.flit_ready;
      rdy = !mb || (xf && exp_q.size() == 1);
      check("flit_valid", link.flit_valid, mb);
      check("busy", busy, mb);
      check("msg_ready", link.msg_ready, rdy);
      if (mb) check("flit_data", link.flit_data, exp_q[0]);
`ifdef NOC_INJ_STATS_EN
      check("stat_flits", stat_flits, m_flits & 32'hFFFF);
      check("stat_msgs", stat_msgs, m_msgs & 32'hFFFF);
`else
      check("stat_flits_tied", stat_flits, 0);
      check("stat_msgs_tied", stat_msgs, 0);
`endif
      if (link.flit_valid && link.flit_ready) sent_log.push_back(link.flit_data);
      if (xf) begin
        void'(exp_q.pop_front());
        m_flits++;
        if (exp_q.size() == 0) m_msgs++;
      end
      if (rdy && link.msg_valid) push_msg(link.msg_data, link.msg_dest_x, link.msg_dest_y);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [15:0] data, input logic [1:0] dx, input logic [1:0] dy);
    link.msg_valid  = 1'b1;
    link.msg_data   = data;
    link.msg_dest_x = dx;
    link.msg_dest_y = dy;
  endtask

  // Expected flits packed first-in-lowest-byte
  task automatic check_log(input string name, input int n, input logic [63:0] exp);
    check({name, "_len"}, sent_log.size(), n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] got;
      got = (i < sent_log.size()) ? sent_log[i] : 8'hxx;
      check($sformatf("%s_flit%0d", name, i), got, exp[8*i +: 8]);
    end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic send_n(input int n);
    int got;
    got = 0;
    link.msg_valid  = 1'b1;
    link.flit_ready = 1'b1;
    for (int c = 0; c < n * NFLITS + 20 && got < n; c++) begin
      link.msg_data   = 16'($urandom);
      link.msg_dest_x = 2'($urandom);
      link.msg_dest_y = 2'($urandom);
      if (link.msg_ready) got++;
      step();
    end
    link.msg_valid = 1'b0;
    repeat (NFLITS + 2) step();
    check("send_n_accepts", got, n);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  localparam logic [63:0] SEQ_A  = 64'h0000_0000_9A95_9C93;
  localparam logic [63:0] SEQ_AB = 64'h3132_3334_9A95_9C93;

  initial begin : main
    logic [7:0] rp, vp;
    link.msg_valid  = 1'b0;
    link.msg_data   = '0;
    link.msg_dest_x = '0;
    link.msg_dest_y = '0;
    link.flit_ready = 1'b1;

    #12;
    check("reset_msg_ready", link.msg_ready, 1);
    step();
    rst_n = 1'b1;

    // 1: single message, no stalls
    sent_log.delete();
    offer(16'hA5C3, 2'd2, 2'd1);
    step();
    link.msg_valid = 1'b0;
    repeat (6) step();
    check_log("single", 4, SEQ_A);
    check("single_busy_after", busy, 0);

    // 2: stall while flit 1 is shown
    sent_log.delete();
    offer(16'hA5C3, 2'd2, 2'd1);
    step();
    link.msg_valid = 1'b0;
    step();
    link.flit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_hold_data", link.flit_data, 8'h9C);
      check("stall_hold_valid", link.flit_valid, 1);
      step();
    end
    check("stall_hold_final", link.flit_data, 8'h9C);
    link.flit_ready = 1'b1;
    repeat (6) step();
    check_log("stall", 4, SEQ_A);

    // 3: back-to-back messages
    sent_log.delete();
    offer(16'hA5C3, 2'd2, 2'd1);
    step();
    offer(16'h1234, 2'd0, 2'd3);
    for (int c = 0; c < 8; c++) begin
      rp[c] = link.msg_ready;
      vp[c] = link.flit_valid;
      if (c == 4) link.msg_valid = 1'b0;
      step();
    end
    repeat (3) step();
    check("b2b_ready_pattern", rp, 8'h88);
    check("b2b_valid_pattern", vp, 8'hFF);
    check_log("b2b", 8, SEQ_AB);

    // 4: offer while busy; changing data before acceptance must be ignored
    sent_log.delete();
    offer(16'hA5C3, 2'd2, 2'd1);
    step();
    link.msg_valid = 1'b0;
    step();
    offer(16'hFFFF, 2'd3, 2'd3);
    check("busy_bp_ready", link.msg_ready, 0);
    check("busy_bp_busy", busy, 1);
    step();
    offer(16'h1234, 2'd0, 2'd3);
    step();
    step();
    link.msg_valid = 1'b0;
    repeat (6) step();
    check_log("busy_bp", 8, SEQ_AB);

    // 5: reset mid-message
    offer(16'hA5C3, 2'd2, 2'd1);
    step();
    link.msg_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", link.flit_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_data", link.flit_data, 0);
    step();
    rst_n = 1'b1;
    check("midrst_ready", link.msg_ready, 1);
    check("midrst_idle", busy, 0);
    sent_log.delete();
    repeat (6) step();
    check("midrst_no_resend", sent_log.size(), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      link.msg_valid  = ($urandom_range(0, 9) < 6);
      link.msg_data   = 16'($urandom);
      link.msg_dest_x = 2'($urandom);
      link.msg_dest_y = 2'($urandom);
      link.flit_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    link.msg_valid  = 1'b0;
    link.flit_ready = 1'b1;
    repeat (8) step();

    // 6: statistics
`ifdef NOC_INJ_STATS_EN
    reset_pulse();
    send_n(3);
    check("stats_flits_3msg", stat_flits, 16'd12);
    check("stats_msgs_3msg", stat_msgs, 16'd3);
    reset_pulse();
    send_n(16384);
    check("stats_flits_wrap", stat_flits, 16'h0000);
    check("stats_msgs_16k", stat_msgs, 16'h4000);
`else
    check("stats_off_flits", stat_flits, 16'h0);
    check("stats_off_msgs", stat_msgs, 16'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
